gs_decimalizer: RTL

Converts the binary option fields of the game state (pixel width, pixel height, palette id) into left-justified decimal digit strings with lengths. The VGA renderer consumes these to draw values on the options screen. The block sits between the game-state/navigation logic and the renderer. It runs a serial double-dabble conversion per field and commits all fields atomically, so the renderer never sees a half-updated value.

---
 rtl/gs_decimalizer_pkg.sv | 24 ++
 rtl/gs_decimalizer_bin2bcd_step.sv | 28 ++
 rtl/gs_decimalizer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/gs_decimalizer_pkg.sv
// Shared game-state definitions for the options-screen decimalizer and its renderer.
package gs_decimalizer_pkg;

  localparam int GS_NUM_FIELDS = 3;
  localparam int GS_IN_W       = 8;
  localparam int GS_DIGITS_MAX = 3;
  localparam int GS_LEN_W      = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_JUSTIFY = 3'd3,
    ST_COMMIT  = 3'd4,
    ST_HOLD    = 3'd5
  } gs_decim_state_e;

  // Decimalized option fields as seen by the VGA renderer.
  typedef struct packed {
    logic [GS_NUM_FIELDS*GS_DIGITS_MAX*4-1:0] digits;
    logic [GS_NUM_FIELDS*GS_LEN_W-1:0]        lens;
  } gs_decim_t;

endpackage

// File: rtl/gs_decimalizer_bin2bcd_step.sv
// One double-dabble step: add 3 to every BCD nibble >= 5, then shift in one binary bit.
module gs_decimalizer_bin2bcd_step #(
  parameter int DIGITS = 3
) (
  input  logic [DIGITS*4-1:0] i_acc,
  input  logic                i_bit,
  output logic [DIGITS*4-1:0] o_acc
);

  logic [DIGITS*4-1:0] w_adj;
  logic                w_unused_carry;

  always_comb begin
    w_adj = i_acc;
    for (int k = 0; k < DIGITS; k++) begin
      if (i_acc[k*4 +: 4] >= 4'd5) begin
        w_adj[k*4 +: 4] = i_acc[k*4 +: 4] + 4'd3;
      end else begin
        w_adj[k*4 +: 4] = i_acc[k*4 +: 4];
      end
    end
  end

  // The top bit never carries for in-range inputs.
  assign w_unused_carry = w_adj[DIGITS*4-1];
  assign o_acc          = {w_adj[DIGITS*4-2:0], i_bit};

endmodule

// File: rtl/gs_decimalizer.sv
// gs_decimalizer: serial double-dabble of the option fields with an atomic commit.
// Define GS_DECIM_VSYNC_COMMIT_EN to defer the commit to the next frame_sync pulse.
module gs_decimalizer
  import gs_decimalizer_pkg::*;
#(
  parameter int NUM_FIELDS = GS_NUM_FIELDS,
  parameter int IN_W       = GS_IN_W,
  parameter int DIGITS     = GS_DIGITS_MAX,
  parameter int LEN_W      = GS_LEN_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [NUM_FIELDS*IN_W-1:0]     values,
  input  logic                           frame_sync,
  output logic [NUM_FIELDS*DIGITS*4-1:0] digits,
  output logic [NUM_FIELDS*LEN_W-1:0]    lens,
  output logic                           busy,
  output logic                           done
);

  localparam int FW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int CW = $clog2(IN_W + 1);
  localparam int ZW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int AW = DIGITS * 4;
  localparam logic [IN_W-1:0] MSB_MASK = {1'b1, {(IN_W-1){1'b0}}};

  gs_decim_state_e             r_state;
  logic [NUM_FIELDS*IN_W-1:0]  r_snap;
  logic [AW-1:0]               r_acc;
  logic [FW-1:0]               r_field;
  logic [CW-1:0]               r_cnt;
  logic                        r_pend;
  logic                        r_start_d;
  logic                        r_busy;
  logic                        r_done;
  logic [NUM_FIELDS*AW-1:0]    r_stage_d;
  logic [NUM_FIELDS*AW-1:0]    r_digits;
  logic [NUM_FIELDS*LEN_W-1:0] r_stage_l;
  logic [NUM_FIELDS*LEN_W-1:0] r_lens;

  logic                        w_req;
  logic [IN_W-1:0]             w_field_val;
  logic [IN_W-1:0]             w_mask;
  logic                        w_bit;
  logic [AW-1:0]               w_step;
  logic [AW-1:0]               w_shifted;
  logic [AW-1:0]               w_just;
  logic [ZW-1:0]               w_z;
  logic                        w_seen;
  logic [LEN_W-1:0]            w_len;

`ifndef GS_DECIM_VSYNC_COMMIT_EN
  logic w_unused_frame_sync;
  assign w_unused_frame_sync = frame_sync;
`endif

  // A start held high for several cycles is a single request.
  assign w_req       = start & ~r_start_d;
  assign w_field_val = r_snap[r_field*IN_W +: IN_W];
  assign w_mask      = MSB_MASK >> r_cnt;
  assign w_bit       = |(w_field_val & w_mask);

  gs_decimalizer_bin2bcd_step #(.DIGITS(DIGITS)) u_step (
    .i_acc (r_acc),
    .i_bit (w_bit),
    .o_acc (w_step)
  );

  // Left-justify the finished accumulator: drop leading zeros, keep at least one digit.
  always_comb begin
    w_z    = '0;
    w_seen = 1'b0;
    for (int k = 0; k < DIGITS - 1; k++) begin
      if (!w_seen && (r_acc[(DIGITS-1-k)*4 +: 4] == 4'd0)) begin
        w_z = w_z + ZW'(1);
      end else begin
        w_seen = 1'b1;
      end
    end
    w_shifted = r_acc << {w_z, 2'b00};
    w_just    = '0;
    for (int k = 0; k < DIGITS; k++) begin
      w_just[k*4 +: 4] = w_shifted[(DIGITS-1-k)*4 +: 4];
    end
    w_len = LEN_W'(DIGITS - int'(w_z));
  end

  assign digits = r_digits;
  assign lens   = r_lens;
  assign busy   = r_busy;
  assign done   = r_done;

  // Conversion sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_snap    <= '0;
      r_acc     <= '0;
      r_field   <= '0;
      r_cnt     <= '0;
      r_pend    <= 1'b0;
      r_start_d <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_stage_d <= '0;
      r_digits  <= '0;
      for (int i = 0; i < NUM_FIELDS; i++) begin
        r_stage_l[i*LEN_W +: LEN_W] <= LEN_W'(1);
        r_lens[i*LEN_W +: LEN_W]    <= LEN_W'(1);
      end
    end else begin
      r_start_d <= start;
      r_done    <= 1'b0;
      if (w_req && (r_state != ST_IDLE)) begin
        r_pend <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_req || r_pend) begin
            r_snap  <= values;
            r_pend  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_acc   <= '0;
          r_field <= '0;
          r_cnt   <= '0;
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(IN_W - 1)) begin
            r_state <= ST_JUSTIFY;
          end
        end
        ST_JUSTIFY: begin
          r_stage_d[r_field*AW +: AW]       <= w_just;
          r_stage_l[r_field*LEN_W +: LEN_W] <= w_len;
          r_acc <= '0;
          r_cnt <= '0;
          if (r_field == FW'(NUM_FIELDS - 1)) begin
`ifdef GS_DECIM_VSYNC_COMMIT_EN
            r_state <= ST_HOLD;
`else
            r_state <= ST_COMMIT;
`endif
          end else begin
            r_field <= r_field + FW'(1);
            r_state <= ST_SHIFT;
          end
        end
        ST_COMMIT: begin
          r_digits <= r_stage_d;
          r_lens   <= r_stage_l;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
        ST_HOLD: begin
`ifdef GS_DECIM_VSYNC_COMMIT_EN
          if (frame_sync) begin
            r_digits <= r_stage_d;
            r_lens   <= r_stage_l;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end
`else
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
`endif
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
